// File: rtl/fifo_byte_packer_pkg.sv
// Shared constants, entry layout and small helpers for the byte-packing FIFO.
package fifo_byte_packer_pkg;

   localparam int FIFO_DEPTH = 8;
   localparam int FIFO_AW    = 3;
   localparam int LW_W       = 32;
   localparam int BV_W       = 4;
   localparam int ENTRY_W    = LW_W + BV_W;

   // Byte-lane indices: lane 0 is the most significant byte (big-endian).
   localparam logic [1:0] LANE_0 = 2'd0;
   localparam logic [1:0] LANE_1 = 2'd1;
   localparam logic [1:0] LANE_2 = 2'd2;
   localparam logic [1:0] LANE_3 = 2'd3;

   // Byte-valid masks for 1..4 bytes held; bit 3 covers bits 31:24.
   localparam logic [3:0] BV_1 = 4'b1000;
   localparam logic [3:0] BV_2 = 4'b1100;
   localparam logic [3:0] BV_3 = 4'b1110;
   localparam logic [3:0] BV_4 = 4'b1111;

   typedef struct packed {
      logic [BV_W-1:0] bv;
      logic [LW_W-1:0] data;
   } lw_entry_t;

   // Byte-valid mask for a partial longword holding n bytes.
   function automatic logic [3:0] bv_for_count(input logic [1:0] n);
      logic [3:0] bv;
      case (n)
         2'd1:    bv = BV_1;
         2'd2:    bv = BV_2;
         2'd3:    bv = BV_3;
         default: bv = 4'b0000;
      endcase
      return bv;
   endfunction

   // 3-bit enable counter step, wraps modulo 8.
   function automatic logic [FIFO_AW-1:0] ptr_next(input logic [FIFO_AW-1:0] p,
                                                   input logic en);
      logic [FIFO_AW-1:0] n;
      if (en) begin
         n = p + 3'd1;
      end else begin
         n = p;
      end
      return n;
   endfunction

   // Place a byte into the selected big-endian lane of a longword.
   function automatic logic [LW_W-1:0] lane_insert(input logic [LW_W-1:0] w,
                                                   input logic [1:0] lane,
                                                   input logic [7:0] b);
      logic [LW_W-1:0] r;
      r = w;
      case (lane)
         LANE_0:  r[31:24] = b;
         LANE_1:  r[23:16] = b;
         LANE_2:  r[15:8]  = b;
         LANE_3:  r[7:0]   = b;
         default: r = w;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/fifo_lw_store.sv
// 8 x 36 longword storage: synchronous write port, asynchronous read port.
module fifo_lw_store
   import fifo_byte_packer_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH,
   parameter int AW    = FIFO_AW,
   parameter int W     = ENTRY_W
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_q [DEPTH];

   // Write the committed entry; contents need no reset since EMPTY masks them.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_byte_packer.sv
// Packs SCSI bytes big-endian into longwords and presents them FWFT to the DMA master.
module fifo_byte_packer
   import fifo_byte_packer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        BYTE_WR,
   input  logic [7:0]  BYTE_IN,
   output logic        BYTE_RDY,
   input  logic        FLUSH,
   output logic        FLUSH_DONE,
   input  logic        LW_RD,
   output logic [31:0] RD_DATA,
   output logic [3:0]  RD_BV,
   output logic        EMPTY,
   output logic        FULL,
   output logic [3:0]  LEVEL,
   output logic        OVR
);

   localparam logic [3:0] LEVEL_FULL = 4'(DEPTH);

   logic [1:0]    bp_q, bp_d;
   logic [31:0]   asm_q, asm_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [3:0]    level_q, level_d;
   logic          ovr_q, ovr_d;
   logic          flush_pend_q, flush_pend_d;
   logic          flush_done_q, flush_done_d;

   logic          empty;
   logic          full;
   logic          byte_rdy;
   logic          byte_acc;
   logic          pop;
   logic          commit;
   logic          word_done;
   logic [1:0]    bp_next;
   logic [31:0]   packed_word;
   lw_entry_t     wr_entry;
   lw_entry_t     rd_entry;

   // Flags come only from registered state so they never loop back through the inputs.
   assign empty    = (level_q == 4'd0);
   assign full     = (level_q == LEVEL_FULL);
   assign byte_rdy = ~(full & (bp_q == LANE_3)) & ~flush_pend_q;

   // Packing, commit/flush decisions and next-state for pointers, LEVEL and flags.
   always_comb begin
      byte_acc     = BYTE_WR & byte_rdy;
      pop          = LW_RD & ~empty;
      packed_word  = asm_q;
      bp_next      = bp_q;
      word_done    = 1'b0;
      commit       = 1'b0;
      wr_entry.bv  = BV_4;
      wr_entry.data = 32'd0;
      bp_d         = bp_q;
      asm_d        = asm_q;
      flush_pend_d = flush_pend_q;
      flush_done_d = 1'b0;
      level_d      = level_q;

      if (byte_acc) begin
         packed_word = lane_insert(asm_q, bp_q, BYTE_IN);
         bp_next     = bp_q + 2'd1;
         word_done   = (bp_q == LANE_3);
      end else begin
         packed_word = asm_q;
         bp_next     = bp_q;
      end

      wr_entry.data = packed_word;
      bp_d          = bp_next;
      asm_d         = packed_word;

      // A completed longword commits with all four lanes valid.
      if (word_done) begin
         commit = 1'b1;
         asm_d  = 32'd0;
      end else begin
         commit = 1'b0;
      end

      // Flush (new or held): nothing partial -> no-op, else commit once a slot is free.
      if (FLUSH | flush_pend_q) begin
         if (bp_next == LANE_0) begin
            flush_done_d = 1'b1;
            flush_pend_d = 1'b0;
         end else if (~full | pop) begin
            commit       = 1'b1;
            wr_entry.bv  = bv_for_count(bp_next);
            bp_d         = LANE_0;
            asm_d        = 32'd0;
            flush_done_d = 1'b1;
            flush_pend_d = 1'b0;
         end else begin
            flush_pend_d = 1'b1;
         end
      end else begin
         flush_pend_d = flush_pend_q;
      end

      case ({commit, pop})
         2'b10:   level_d = level_q + 4'd1;
         2'b01:   level_d = level_q - 4'd1;
         default: level_d = level_q;
      endcase
   end

   assign ovr_d  = ovr_q | (BYTE_WR & ~byte_rdy);
   assign wptr_d = ptr_next(wptr_q, commit);
   assign rptr_d = ptr_next(rptr_q, pop);

   // State register with synchronous reset that discards entries, partial word and pending flush.
   always_ff @(posedge CLK) begin
      if (RST) begin
         bp_q         <= 2'd0;
         asm_q        <= 32'd0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         level_q      <= 4'd0;
         ovr_q        <= 1'b0;
         flush_pend_q <= 1'b0;
         flush_done_q <= 1'b0;
      end else begin
         bp_q         <= bp_d;
         asm_q        <= asm_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         level_q      <= level_d;
         ovr_q        <= ovr_d;
         flush_pend_q <= flush_pend_d;
         flush_done_q <= flush_done_d;
      end
   end

   fifo_lw_store #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (ENTRY_W)
   ) u_store (
      .clk   (CLK),
      .we    (commit),
      .waddr (wptr_q),
      .wdata (wr_entry),
      .raddr (rptr_q),
      .rdata (rd_entry)
   );

   // Head entry is forced to zero while empty so reset shows RD_DATA=0, RD_BV=0.
   assign RD_DATA    = empty ? 32'd0 : rd_entry.data;
   assign RD_BV      = empty ? 4'd0  : rd_entry.bv;
   assign EMPTY      = empty;
   assign FULL       = full;
   assign LEVEL      = level_q;
   assign BYTE_RDY   = byte_rdy;
   assign FLUSH_DONE = flush_done_q;
   assign OVR        = ovr_q;

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Randomized + directed bench for fifo_byte_packer against a queue-based model.
module tb_fifo_byte_packer;

   logic        CLK = 1'b0;
   logic        RST;
   logic        BYTE_WR;
   logic [7:0]  BYTE_IN;
   logic        BYTE_RDY;
   logic        FLUSH;
   logic        FLUSH_DONE;
   logic        LW_RD;
   logic [31:0] RD_DATA;
   logic [3:0]  RD_BV;
   logic        EMPTY;
   logic        FULL;
   logic [3:0]  LEVEL;
   logic        OVR;

   fifo_byte_packer dut (
      .CLK(CLK), .RST(RST), .BYTE_WR(BYTE_WR), .BYTE_IN(BYTE_IN), .BYTE_RDY(BYTE_RDY),
      .FLUSH(FLUSH), .FLUSH_DONE(FLUSH_DONE), .LW_RD(LW_RD), .RD_DATA(RD_DATA),
      .RD_BV(RD_BV), .EMPTY(EMPTY), .FULL(FULL), .LEVEL(LEVEL), .OVR(OVR)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   // Model: a queue of {bv, data} entries plus the bytes gathered so far.
   logic [35:0] mq[$];
   logic [7:0]  mpart[4];
   int          mbp;
   bit          movr;
   bit          mpend;
   bit          mdone;

   function automatic void model_reset();
      mq.delete();
      for (int i = 0; i < 4; i++) mpart[i] = 8'h00;
      mbp   = 0;
      movr  = 1'b0;
      mpend = 1'b0;
      mdone = 1'b0;
   endfunction

   function automatic void model_push(input logic [3:0] bv);
      mq.push_back({bv, mpart[0], mpart[1], mpart[2], mpart[3]});
      for (int i = 0; i < 4; i++) mpart[i] = 8'h00;
      mbp = 0;
   endfunction

   function automatic bit model_rdy();
      return !((mq.size() == 8) && (mbp == 3)) && !mpend;
   endfunction

   function automatic void model_step(input bit wr, input logic [7:0] b,
                                      input bit fl, input bit rd);
      bit full_now, rdy, pop;
      logic [3:0] bv;
      full_now = (mq.size() == 8);
      rdy      = model_rdy();
      pop      = rd && (mq.size() != 0);
      mdone    = 1'b0;
      if (wr && !rdy) movr = 1'b1;
      if (pop) void'(mq.pop_front());
      if (wr && rdy) begin
         mpart[mbp] = b;
         mbp++;
         if (mbp == 4) model_push(4'b1111);
      end
      if (fl || mpend) begin
         if (mbp == 0) begin
            mdone = 1'b1;
            mpend = 1'b0;
         end else if (!full_now || pop) begin
            bv = 4'b1111;
            bv = bv << (4 - mbp);
            model_push(bv);
            mdone = 1'b1;
            mpend = 1'b0;
         end else begin
            mpend = 1'b1;
         end
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every DUT output against the model.
   task automatic check_all();
      logic [35:0] h;
      h = (mq.size() != 0) ? mq[0] : 36'd0;
      chk("EMPTY",      32'(EMPTY),      32'(mq.size() == 0));
      chk("FULL",       32'(FULL),       32'(mq.size() == 8));
      chk("LEVEL",      32'(LEVEL),      32'(mq.size()));
      chk("BYTE_RDY",   32'(BYTE_RDY),   32'(model_rdy()));
      chk("FLUSH_DONE", 32'(FLUSH_DONE), 32'(mdone));
      chk("OVR",        32'(OVR),        32'(movr));
      chk("RD_DATA",    RD_DATA,         h[31:0]);
      chk("RD_BV",      32'(RD_BV),      32'(h[35:32]));
   endtask

   // One clock: drive at negedge, advance model, check at the following negedge.
   task automatic cyc(input bit rst, input bit wr, input logic [7:0] b,
                      input bit fl, input bit rd);
      RST     = rst;
      BYTE_WR = wr;
      BYTE_IN = b;
      FLUSH   = fl;
      LW_RD   = rd;
      if (rst) model_reset();
      else     model_step(wr, b, fl, rd);
      @(posedge CLK);
      @(negedge CLK);
      RST     = 1'b0;
      BYTE_WR = 1'b0;
      FLUSH   = 1'b0;
      LW_RD   = 1'b0;
      check_all();
   endtask

   task automatic wr_byte(input logic [7:0] b);
      cyc(1'b0, 1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic fill_bytes(input int n);
      for (int i = 0; i < n; i++) wr_byte(8'($urandom));
   endtask

   initial begin
      RST = 1'b1; BYTE_WR = 1'b0; BYTE_IN = 8'h00; FLUSH = 1'b0; LW_RD = 1'b0;
      model_reset();

      // Reset state
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("rst_empty", 32'(EMPTY), 32'd1);
      chk("rst_rdy",   32'(BYTE_RDY), 32'd1);
      chk("rst_data",  RD_DATA, 32'd0);

      // Four bytes make one full longword
      wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33); wr_byte(8'h44);
      chk("lw_data",  RD_DATA, 32'h11223344);
      chk("lw_bv",    32'(RD_BV), 32'h0000000f);
      chk("lw_level", 32'(LEVEL), 32'd1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

      // Two bytes then flush
      wr_byte(8'hAA); wr_byte(8'hBB);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("fl_data", RD_DATA, 32'hAABB0000);
      chk("fl_bv",   32'(RD_BV), 32'h0000000c);
      chk("fl_done", 32'(FLUSH_DONE), 32'd1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("fl_done_off", 32'(FLUSH_DONE), 32'd0);
      // Flush with nothing partial is a no-op that still completes
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("fl_noop", 32'(FLUSH_DONE), 32'd1);
      // Byte plus flush in the same cycle includes the byte
      wr_byte(8'h5A);
      cyc(1'b0, 1'b1, 8'hC3, 1'b1, 1'b0);
      chk("wrfl_data", RD_DATA, 32'h5AC30000);

      // 36 bytes with no reads: fill, then overrun
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      fill_bytes(36);
      chk("ovr_full", 32'(FULL), 32'd1);
      chk("ovr_rdy",  32'(BYTE_RDY), 32'd0);
      chk("ovr_flag", 32'(OVR), 32'd1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovr_rdy_back", 32'(BYTE_RDY), 32'd1);
      fill_bytes(2);

      // FULL with BP=2, flush held until a pop
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      fill_bytes(34);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("pend_rdy", 32'(BYTE_RDY), 32'd0);
      cyc(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("pend_level", 32'(LEVEL), 32'd8);
      chk("pend_done",  32'(FLUSH_DONE), 32'd1);
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

      // Streaming with reads whenever non-empty
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 64; i++) cyc(1'b0, 1'b1, 8'(i * 7 + 3), 1'b0, mq.size() != 0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

      // Reset mid-operation with LEVEL=5 and BP=2
      fill_bytes(22);
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("mrst_empty", 32'(EMPTY), 32'd1);
      chk("mrst_level", 32'(LEVEL), 32'd0);
      chk("mrst_rdy",   32'(BYTE_RDY), 32'd1);

      // Randomized traffic with varying read pressure
      for (int i = 0; i < 3000; i++) begin
         int rdp;
         rdp = ((i / 300) % 2 == 0) ? 2 : 6;
         cyc($urandom_range(0, 399) == 0,
             $urandom_range(0, 9) < 7,
             8'($urandom),
             $urandom_range(0, 14) == 0,
             $urandom_range(0, 9) < rdp);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fifo_byte_packer.md
# fifo_byte_packer

Byte-to-longword packing FIFO for the SCSI-to-memory DMA path. Accepts single bytes from the SCSI controller side and packs them big-endian into 32-bit longwords. Stores up to 8 longwords and presents them first-word-fall-through to the DMA bus master, which pops whole longwords. Its 3-bit write and read pointers are the FIFO's wrap-around entry counters.

## Interface
Parameters:
- DEPTH, 8, number of longword entries; fixed at 8 (3-bit pointers).
- AW, 3, pointer width; equal to log2(DEPTH).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- BYTE_WR  in  1  write strobe for BYTE_IN; one byte per asserted cycle.
- BYTE_IN  in  8  byte from the SCSI side.
- BYTE_RDY  out  1  the packer can take a byte this cycle.
- FLUSH  in  1  one-cycle request to commit a partial longword.
- FLUSH_DONE  out  1  one-cycle pulse when the flush has completed.
- LW_RD  in  1  pops the head longword.
- RD_DATA  out  32  head longword.
- RD_BV  out  4  byte-valid mask of the head entry; bit 3 is bits 31:24.
- EMPTY  out  1  no committed entries.
- FULL  out  1  8 committed entries.
- LEVEL  out  4  committed entry count, 0..8.
- OVR  out  1  sticky flag: a byte was written while BYTE_RDY was low.

## Operation
- Packing is big-endian. A 2-bit byte pointer BP selects the lane: BP=0 goes to [31:24], BP=1 to [23:16], BP=2 to [15:8], BP=3 to [7:0]. Every accepted byte increments BP, which wraps from 3 to 0.
- A byte accepted at BP=3 commits the assembled longword at WPTR with RD_BV=4'b1111. WPTR then increments modulo 8.
- BYTE_RDY = ~(FULL & BP==3) & ~flush_pend. A BYTE_WR while BYTE_RDY is low is dropped and sets OVR. OVR clears only on RST.
- FLUSH behaviour:
  - With BP=0: FLUSH_DONE pulses the next cycle and nothing is committed.
  - With BP≠0 and not FULL: the partial longword is committed. Unwritten lanes are 0 and RD_BV holds the written lanes (BP=1 → 1000, BP=2 → 1100, BP=3 → 1110). BP resets to 0.
  - With BP≠0 and FULL: flush_pend is set. The commit happens in the first cycle that is not FULL (a pop frees the slot in that same cycle).
- BYTE_WR and FLUSH in the same cycle: the byte is packed first. If that byte completes the longword, the normal commit happens and the flush acts as the BP=0 case. Otherwise the partial longword, including the new byte, is flushed.
- Read side: RD_DATA and RD_BV always show the entry at RPTR, and are valid whenever EMPTY=0. LW_RD with EMPTY=0 increments RPTR modulo 8. LW_RD with EMPTY=1 is ignored and has no side effect.
- A commit and a pop in the same cycle leave LEVEL unchanged. A commit while FULL cannot occur, because BYTE_RDY and the flush hold prevent it.
- Reset values: BP=0, WPTR=RPTR=0, LEVEL=0, EMPTY=1, FULL=0, BYTE_RDY=1, FLUSH_DONE=0, OVR=0, flush_pend=0, RD_BV=0, RD_DATA=0. Storage contents are don't-care.
- Reset mid-operation discards every entry and any partial longword or pending flush, in the same edge.

## Timing
- Byte to visible entry: the 4th byte is accepted on edge N. EMPTY falls and RD_DATA is valid after edge N, which is 1 cycle of latency.
- Pop: LW_RD on edge N. The next entry, or EMPTY=1, is visible after edge N.
- FLUSH_DONE is registered and pulses exactly 1 cycle after the cycle in which the commit (or the no-op) occurs.
- EMPTY, FULL, LEVEL and BYTE_RDY all derive from registered state; none depends combinationally on BYTE_WR, LW_RD or FLUSH.
- LEVEL is stored 4 bits wide. FULL = LEVEL==8, EMPTY = LEVEL==0. Pointer equality alone is not used because it is ambiguous at wrap.

## Structure
- Shared FIFO package holds: FIFO_DEPTH=8, FIFO_AW=3, LW_W=32, byte-lane index constants, and the BV mask constants BV_1/BV_2/BV_3/BV_4.
- One sub-module: fifo_lw_store, the 8×36 storage array (32 data bits + 4 BV bits). It has a write port at WPTR and an asynchronous read at RPTR.
- The pointers reuse the team's 3-bit enable counter for both WPTR and RPTR.
- Packing, flush control, flags and LEVEL live in the top level.

## Test plan
- Write bytes 0x11,0x22,0x33,0x44 → after the 4th edge: EMPTY=0, RD_DATA=0x11223344, RD_BV=1111, LEVEL=1.
- Write 0xAA,0xBB then FLUSH → one commit with RD_DATA=0xAABB0000 and RD_BV=1100. FLUSH_DONE pulses 1 cycle after the commit, then BP=0.
- Write 36 bytes (9 longwords) with no reads → FULL=1 and BYTE_RDY falls when BP=3 with 8 entries held; the extra bytes set OVR=1. One LW_RD then restores BYTE_RDY=1.
- With FULL and BP=2, FLUSH → flush_pend holds and BYTE_RDY=0. LW_RD commits the partial entry in the same cycle, LEVEL stays 8, and FLUSH_DONE pulses 1 cycle later.
- Stream 64 bytes with LW_RD asserted whenever EMPTY=0 → the pointers wrap twice and the data order is preserved. Simultaneous commit and pop keep LEVEL steady.
- Assert RST with LEVEL=5 and BP=2 → the next cycle shows EMPTY=1, LEVEL=0, OVR=0 and BYTE_RDY=1.
